// File: rtl/iter_divider.sv
// Restoring shift-and-subtract divider for DIV/DIVU.
// One quotient bit per clock, then a sign/zero fix-up cycle.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] rem, quo, dmag, dvd_raw;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, sign_r, dzero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits, last;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // Extra headroom bit: shifted partial remainder may exceed WIDTH bits
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dmag};
  assign fits    = ~diff[WIDTH+1];
  assign last    = (cnt == CNT_W'(1));

  // Divide by zero overrides the sign fix-up
  assign q_fix = dzero  ? '1 :
                 sign_q ? -quo : quo;
  assign r_fix = dzero  ? dvd_raw :
                 sign_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        if (cancel)    nxt = IDLE;
        else if (last) nxt = FIX;
      end
      FIX:  nxt = cancel ? IDLE : DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      quo       <= '0;
      dmag      <= '0;
      dvd_raw   <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dzero     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (state == IDLE && start) begin
        rem     <= '0;
        quo     <= a_mag;
        dmag    <= b_mag;
        dvd_raw <= dividend;
        dzero   <= (divisor == '0);
        sign_q  <= a_neg ^ b_neg;
        sign_r  <= a_neg;
        cnt     <= CNT_W'(WIDTH);
      end else if (state == RUN && !cancel) begin
        rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], fits};
        cnt <= cnt - CNT_W'(1);
      end else if (state == FIX && !cancel) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: latency, results,
// boundaries, cancel, ignored start, back-to-back, async reset.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy, done;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] sbq[$];
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  always #5 clk = ~clk;

  iter_divider dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .cancel(cancel),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder)
  );

  function automatic logic [63:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic s
  );
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {qv[31:0], rv[31:0]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    sbq.push_back(model(a, b, s));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done is seen
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h, want all 0",
               busy, done, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cases(input string name, input logic s,
                            input logic [31:0] av[4],
                            input logic [31:0] bv[4]);
    int cyc;
    bit bok;
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      issue(av[i], bv[i], s);
      wait_done(cyc, bok);
      e = sbq.pop_front();
      n_cmp++;
      if (cyc !== 34) begin
        n_bad++;
        $display("FAIL %s[%0d] latency: got %0d want 34", name, i, cyc);
      end
      n_cmp++;
      if (!bok) begin
        n_bad++;
        $display("FAIL %s[%0d] busy: got profile error want 1..33",
                 name, i);
      end
      n_cmp++;
      if ({quotient, remainder} !== e) begin
        n_bad++;
        $display("FAIL %s[%0d] result: got q=%h r=%h want q=%h r=%h",
                 name, i, quotient, remainder, e[63:32], e[31:0]);
      end
      prev_q = e[63:32];
      prev_r = e[31:0];
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] a[4] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF};
    logic [31:0] b[4] = '{32'd7, 32'd1, 32'd9, 32'h0000_1234};
    test_cases("unsigned", 1'b0, a, b);
  endtask

  task automatic test_signed();
    logic [31:0] a[4] = '{32'hFFFF_FF9C, 32'd100, 32'h8000_0000,
                          32'hFFFF_FFF9};
    logic [31:0] b[4] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                          32'hFFFF_FFFE};
    test_cases("signed", 1'b1, a, b);
  endtask

  task automatic test_div_zero();
    logic [31:0] a[4] = '{32'h1234_5678, 32'h8765_4321, 32'd0, 32'd1};
    logic [31:0] b[4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    test_cases("divzero_u", 1'b0, a, b);
    test_cases("divzero_s", 1'b1, a, b);
  endtask

  task automatic test_cancel();
    bit seen;
    issue(32'd1000, 32'd3, 1'b0);
    void'(sbq.pop_back());
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_idle: busy=%b want 0", busy);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL cancel_nodone: activity seen=%b want 0", seen);
    end
    n_cmp++;
    if (quotient !== prev_q || remainder !== prev_r) begin
      n_bad++;
      $display("FAIL cancel_hold: got q=%h r=%h want q=%h r=%h",
               quotient, remainder, prev_q, prev_r);
    end
  endtask

  task automatic test_start_in_run();
    int cyc;
    bit bok;
    logic [63:0] e;
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bok);
    e = sbq.pop_front();
    n_cmp++;
    if (cyc + 6 !== 34) begin
      n_bad++;
      $display("FAIL ignore_start latency: got %0d want 34", cyc + 6);
    end
    n_cmp++;
    if ({quotient, remainder} !== e) begin
      n_bad++;
      $display("FAIL ignore_start result: got q=%h r=%h want q=%h r=%h",
               quotient, remainder, e[63:32], e[31:0]);
    end
    bok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy) bok = 1'b0;
    end
    n_cmp++;
    if (!bok) begin
      n_bad++;
      $display("FAIL ignore_start queued: busy seen, want idle");
    end
    prev_q = e[63:32];
    prev_r = e[31:0];
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bok;
    logic [63:0] e;
    issue(32'd77, 32'd5, 1'b0);
    wait_done(cyc, bok);
    e = sbq.pop_front();
    n_cmp++;
    if ({quotient, remainder} !== e) begin
      n_bad++;
      $display("FAIL b2b first: got q=%h r=%h want q=%h r=%h",
               quotient, remainder, e[63:32], e[31:0]);
    end
    issue(32'hFFFF_FF00, 32'd16, 1'b1);
    wait_done(cyc, bok);
    e = sbq.pop_front();
    n_cmp++;
    if (cyc !== 34 || {quotient, remainder} !== e) begin
      n_bad++;
      $display("FAIL b2b second: got c=%0d q=%h r=%h want c=34 q=%h r=%h",
               cyc, quotient, remainder, e[63:32], e[31:0]);
    end
    prev_q = e[63:32];
    prev_r = e[31:0];
  endtask

  task automatic test_async_reset();
    int cyc;
    bit bok;
    logic [63:0] e;
    issue(32'd999, 32'd4, 1'b0);
    void'(sbq.pop_back());
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, quotient, remainder} !== 66'd0) begin
      n_bad++;
      $display("FAIL async_rst: busy=%b done=%b q=%h r=%h want all 0",
               busy, done, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(cyc, bok);
    e = sbq.pop_front();
    n_cmp++;
    if (quotient !== 32'd14 || remainder !== 32'd2 ||
        {quotient, remainder} !== e) begin
      n_bad++;
      $display("FAIL post_rst: got q=%h r=%h want q=0000000e r=00000002",
               quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel();
    test_start_in_run();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
